// File: rtl/grid_ram_arbiter.sv
// Shares one single-port tile-grid RAM between the raster display (fixed slots
// every 16th visible pixel) and a game-logic read/write channel.
module grid_ram_arbiter #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        h_visable,
  input  logic        v_visable,
  input  logic        wr_req,
  input  logic [10:0] wr_addr,
  input  logic [1:0]  wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [10:0] rd_addr,
  output logic        rd_ack,
  output logic [1:0]  rd_data,
  output logic [10:0] ram_addr,
  output logic        ram_we,
  output logic [1:0]  ram_wdata,
  input  logic [1:0]  ram_rdata,
  output logic [1:0]  tile_code,
  output logic        tile_valid,
  output logic        frame_tick
);

  localparam int DEPTH = COLS * ROWS;

  typedef enum logic [1:0] {
    IDLE,
    WR_ACK,
    RD_WAIT,
    RD_ACK
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_rd;
  logic        r_rd_oob;
  logic [1:0]  r_rd_data;
  logic [1:0]  r_tile_code;
  logic        r_slot_d;
  logic        r_vis_d1;
  logic        r_vis_d2;
  logic        r_frame_tick;

  logic        w_slot;
  logic        w_grant_wr;
  logic        w_grant_rd;
  logic        w_wr_oob;
  logic        w_rd_oob;
  logic [10:0] w_disp_addr;

  assign w_slot      = v_visable && (hcount < 10'd640) && (hcount[3:0] == 4'd0);
  assign w_disp_addr = 11'((32'(vcount >> 4) * COLS) + 32'(hcount >> 4));
  assign w_wr_oob    = (32'(wr_addr) >= DEPTH);
  assign w_rd_oob    = (32'(rd_addr) >= DEPTH);

  // Grants only in non-slot IDLE cycles; on a tie the channel not served last wins.
  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if (!rst && (r_state == IDLE) && !w_slot) begin
      if (wr_req && rd_req) begin
        w_grant_wr = r_last_rd;
        w_grant_rd = !r_last_rd;
      end else begin
        w_grant_wr = wr_req;
        w_grant_rd = rd_req;
      end
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (w_slot) begin
      ram_addr = w_disp_addr;
    end else if (w_grant_wr) begin
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
      ram_we    = !w_wr_oob;
    end else if (w_grant_rd) begin
      ram_addr = rd_addr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_wr) begin
          w_state_nxt = WR_ACK;
        end else if (w_grant_rd) begin
          w_state_nxt = RD_WAIT;
        end
      end
      WR_ACK:  w_state_nxt = IDLE;
      RD_WAIT: w_state_nxt = RD_ACK;
      RD_ACK:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_rd    <= 1'b1;
      r_rd_oob     <= 1'b0;
      r_rd_data    <= '0;
      r_tile_code  <= '0;
      r_slot_d     <= 1'b0;
      r_vis_d1     <= 1'b0;
      r_vis_d2     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_wr || w_grant_rd) begin
        r_last_rd <= w_grant_rd;
      end
      if (w_grant_rd) begin
        r_rd_oob <= w_rd_oob;
      end
      // RAM word for the granted read is on ram_rdata during RD_WAIT.
      if (r_state == RD_WAIT) begin
        r_rd_data <= r_rd_oob ? 2'b00 : ram_rdata;
      end
      r_slot_d <= w_slot;
      if (r_slot_d) begin
        r_tile_code <= ram_rdata;
      end
      r_vis_d1     <= h_visable && v_visable;
      r_vis_d2     <= r_vis_d1;
      r_frame_tick <= (hcount == 10'd0) && (vcount == 10'd480);
    end
  end

  assign wr_ack     = (r_state == WR_ACK);
  assign rd_ack     = (r_state == RD_ACK);
  assign rd_data    = r_rd_data;
  assign tile_code  = r_tile_code;
  assign tile_valid = r_vis_d2;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_grid_ram_arbiter.sv
// Directed bench for grid_ram_arbiter with a behavioural single-port RAM
// (1-cycle read latency) attached to the RAM port.
module tb_grid_ram_arbiter;

  logic        pixel_clk;
  logic        rst;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        h_visable;
  logic        v_visable;
  logic        wr_req;
  logic [10:0] wr_addr;
  logic [1:0]  wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [10:0] rd_addr;
  logic        rd_ack;
  logic [1:0]  rd_data;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [1:0]  ram_wdata;
  logic [1:0]  ram_rdata;
  logic [1:0]  tile_code;
  logic        tile_valid;
  logic        frame_tick;

  logic        pre_we;
  logic [10:0] pre_addr;
  logic [1:0]  pre_data;
  logic [1:0]  mem [0:2047];

  int total;
  int bad;

  grid_ram_arbiter #(.COLS(40), .ROWS(30)) dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .hcount    (hcount),
    .vcount    (vcount),
    .h_visable (h_visable),
    .v_visable (v_visable),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .tile_code (tile_code),
    .tile_valid(tile_valid),
    .frame_tick(frame_tick)
  );

  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  // Preload port takes precedence so the grid can be seeded during reset.
  always @(posedge pixel_clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge pixel_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic blank();
    hcount    = 10'd700;
    vcount    = 10'd500;
    h_visable = 1'b0;
    v_visable = 1'b0;
  endtask

  initial begin
    int n_pulse;
    int n_misplaced;
    logic prev_hit;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    blank();
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    #2;
    pre_we = 1'b1; pre_addr = 11'd41;   pre_data = 2'd3; tick();
    pre_addr = 11'd42;   pre_data = 2'd1; tick();
    pre_addr = 11'd3;    pre_data = 2'd2; tick();
    pre_addr = 11'd2047; pre_data = 2'd1; tick();
    pre_we = 1'b0; tick();

    chk("rst_wr_ack", 32'(wr_ack), 0);
    chk("rst_rd_ack", 32'(rd_ack), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_tile_code", 32'(tile_code), 0);
    chk("rst_tile_valid", 32'(tile_valid), 0);
    chk("rst_frame_tick", 32'(frame_tick), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);

    // Concurrent requests straight out of reset: W, R, W, R, W.
    rst = 1'b0;
    wr_req = 1'b1; wr_addr = 11'd100; wr_data = 2'd1;
    rd_req = 1'b1; rd_addr = 11'd100;
    #1;
    chk("tie0_we", 32'(ram_we), 1);
    chk("tie0_addr", 32'(ram_addr), 100);
    chk("tie0_wdata", 32'(ram_wdata), 1);
    tick();
    chk("tie0_wr_ack", 32'(wr_ack), 1);
    chk("tie0_no_regrant", 32'(ram_we), 0);
    chk("tie0_rd_ack", 32'(rd_ack), 0);
    wr_req = 1'b0;
    tick();
    wr_req = 1'b1; wr_addr = 11'd101; wr_data = 2'd2;
    #1;
    chk("tie1_we", 32'(ram_we), 0);
    chk("tie1_addr", 32'(ram_addr), 100);
    tick();
    chk("tie1_wait_rd_ack", 32'(rd_ack), 0);
    chk("tie1_wait_addr", 32'(ram_addr), 0);
    tick();
    chk("tie1_rd_ack", 32'(rd_ack), 1);
    chk("tie1_rd_data", 32'(rd_data), 1);
    rd_req = 1'b0;
    tick();
    rd_req = 1'b1; rd_addr = 11'd101;
    #1;
    chk("tie2_we", 32'(ram_we), 1);
    chk("tie2_addr", 32'(ram_addr), 101);
    chk("tie2_rd_data_hold", 32'(rd_data), 1);
    tick();
    chk("tie2_wr_ack", 32'(wr_ack), 1);
    wr_req = 1'b0;
    tick();
    wr_req = 1'b1; wr_addr = 11'd102; wr_data = 2'd3;
    #1;
    chk("tie3_we", 32'(ram_we), 0);
    chk("tie3_addr", 32'(ram_addr), 101);
    tick();
    tick();
    chk("tie3_rd_ack", 32'(rd_ack), 1);
    chk("tie3_rd_data", 32'(rd_data), 2);
    rd_req = 1'b0;
    tick();
    #1;
    chk("tie4_we", 32'(ram_we), 1);
    chk("tie4_addr", 32'(ram_addr), 102);
    tick();
    chk("tie4_wr_ack", 32'(wr_ack), 1);
    wr_req = 1'b0;
    tick();

    // Lone write of addr 5 then read back.
    wr_req = 1'b1; wr_addr = 11'd5; wr_data = 2'd2;
    #1;
    chk("w5_we", 32'(ram_we), 1);
    chk("w5_addr", 32'(ram_addr), 5);
    chk("w5_wdata", 32'(ram_wdata), 2);
    tick();
    chk("w5_ack", 32'(wr_ack), 1);
    wr_req = 1'b0;
    tick();
    chk("w5_ack_one_cycle", 32'(wr_ack), 0);
    rd_req = 1'b1; rd_addr = 11'd5;
    #1;
    chk("r5_addr", 32'(ram_addr), 5);
    chk("r5_we", 32'(ram_we), 0);
    tick();
    chk("r5_wait_ack", 32'(rd_ack), 0);
    tick();
    chk("r5_ack", 32'(rd_ack), 1);
    chk("r5_data", 32'(rd_data), 2);
    rd_req = 1'b0;
    tick();
    chk("r5_ack_drop", 32'(rd_ack), 0);
    chk("r5_data_hold", 32'(rd_data), 2);

    // Out-of-range addresses.
    wr_req = 1'b1; wr_addr = 11'd1200; wr_data = 2'd3;
    #1;
    chk("oobw_we", 32'(ram_we), 0);
    tick();
    chk("oobw_ack", 32'(wr_ack), 1);
    chk("oobw_we_ack", 32'(ram_we), 0);
    wr_req = 1'b0;
    tick();
    rd_req = 1'b1; rd_addr = 11'd2047;
    tick();
    tick();
    chk("oobr_ack", 32'(rd_ack), 1);
    chk("oobr_data", 32'(rd_data), 0);
    rd_req = 1'b0;
    tick();

    // Display slot at row 1, column 1, then column 2.
    v_visable = 1'b1; h_visable = 1'b1; vcount = 10'd16;
    for (int h = 16; h <= 34; h++) begin
      hcount = 10'(h);
      #1;
      if (h == 16) begin
        chk("slot41_addr", 32'(ram_addr), 41);
        chk("slot41_we", 32'(ram_we), 0);
      end
      if (h == 32) chk("slot42_addr", 32'(ram_addr), 42);
      if (h == 17) chk("tile_valid_d1", 32'(tile_valid), 0);
      if (h == 18) chk("tile_valid_d2", 32'(tile_valid), 1);
      chk($sformatf("tile_code_h%0d", h), 32'(tile_code), (h < 18) ? 0 : ((h < 34) ? 3 : 1));
      tick();
    end
    blank();
    tick();

    // Request colliding with slots at row 0.
    v_visable = 1'b1; h_visable = 1'b1; vcount = 10'd0;
    for (int h = 32; h <= 50; h++) begin
      hcount = 10'(h);
      if (h == 32) begin
        wr_req = 1'b1; wr_addr = 11'd7; wr_data = 2'd1;
      end
      if (h == 47) begin
        rd_req = 1'b1; rd_addr = 11'd5;
      end
      #1;
      if (h == 32) begin
        chk("col_slot_we", 32'(ram_we), 0);
        chk("col_slot_addr", 32'(ram_addr), 2);
      end
      if (h == 33) begin
        chk("col_grant_we", 32'(ram_we), 1);
        chk("col_grant_addr", 32'(ram_addr), 7);
      end
      if (h == 34) chk("col_wr_ack", 32'(wr_ack), 1);
      if (h == 47) chk("col_rd_addr", 32'(ram_addr), 5);
      if (h == 48) begin
        chk("col_slot48_addr", 32'(ram_addr), 3);
        chk("col_slot48_we", 32'(ram_we), 0);
      end
      if (h == 49) begin
        chk("col_rd_ack", 32'(rd_ack), 1);
        chk("col_rd_data", 32'(rd_data), 2);
      end
      if (h == 50) chk("col_tile_code", 32'(tile_code), 2);
      if (h == 34) wr_req = 1'b0;
      if (h == 49) rd_req = 1'b0;
      tick();
    end
    blank();
    tick();

    // Reset in the middle of a read.
    rd_req = 1'b1; rd_addr = 11'd5;
    #1;
    chk("rr_grant_addr", 32'(ram_addr), 5);
    tick();
    rst = 1'b1; rd_req = 1'b0;
    tick();
    chk("rr_rd_ack", 32'(rd_ack), 0);
    chk("rr_rd_data", 32'(rd_data), 0);
    chk("rr_wr_ack", 32'(wr_ack), 0);
    chk("rr_tile_code", 32'(tile_code), 0);
    chk("rr_tile_valid", 32'(tile_valid), 0);
    chk("rr_frame_tick", 32'(frame_tick), 0);
    chk("rr_ram_we", 32'(ram_we), 0);
    chk("rr_ram_addr", 32'(ram_addr), 0);
    chk("rr_ram_wdata", 32'(ram_wdata), 0);
    rst = 1'b0;
    tick();
    chk("rr_rd_ack_late", 32'(rd_ack), 0);

    // Compressed raster: 8 clocks per line, 525 lines, two frames.
    n_pulse = 0;
    n_misplaced = 0;
    prev_hit = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int v = 0; v < 525; v++) begin
        for (int h = 0; h < 8; h++) begin
          hcount = 10'(h);
          vcount = 10'(v);
          #1;
          if (frame_tick) n_pulse++;
          if (frame_tick !== prev_hit) n_misplaced++;
          prev_hit = (h == 0) && (v == 480);
          tick();
        end
      end
    end
    #1;
    if (frame_tick !== prev_hit) n_misplaced++;
    chk("frame_pulses", 32'(n_pulse), 2);
    chk("frame_misplaced", 32'(n_misplaced), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
